pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 6-stage MIPS core (PC, IF, ID, EX, MEM, WB). It merges per-stage stall requests into the shared stall bus used by every pipeline register, including the EX/MEM register. It also turns MEM-stage exceptions into a one-cycle flush plus a redirect PC. A small FSM masks the refill window after a flush and keeps stall-monitoring counters.

Parameters:
EXC_VECTOR, 32'h0000_0020, handler entry address for all exceptions except eret
MAX_STALL, 16, consecutive stalled cycles that set the sticky timeout flag (must be >= 1)
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
stallreq_if  in  1  IF stage requests stall (instruction fetch wait)
stallreq_id  in  1  ID stage requests stall (load-use hazard)
stallreq_ex  in  1  EX stage requests stall (div, madd/msub second cycle)
stallreq_mem  in  1  MEM stage requests stall (data bus wait)
exc_valid  in  1  MEM-stage instruction carries an exception this cycle
exc_code  in  5  exception code: 1 int, 8 syscall, 9 break, 10 ri, 12 ov, 13 trap, 14 eret
cp0_epc  in  32  current CP0 EPC, used as the eret target
ctr_clr  in  1  synchronous clear of stall_cycles and stall_timeout
stall  out  6  stall bus; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = stop
flush  out  1  flush all pipeline registers (one-cycle pulse)
new_pc  out  32  redirect target; valid only while flush=1
stall_cycles  out  CNT_W  saturating count of cycles with stall!=0
stall_timeout  out  1  sticky flag: a stall run reached MAX_STALL cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - stall=0, flush=0, new_pc=0, stall_cycles=0, stall_timeout=0.
  - Internal run counter=0, state=RUN.
- FSM states: RUN and REFILL.
- RUN, exc_valid=0: stall is combinational from the requests, with priority mem > ex > id > if:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
  - flush=0.
- RUN, exc_valid=1:
  - Same cycle (Mealy): flush=1 and stall=0, regardless of any stall request.
  - new_pc = cp0_epc if exc_code=14, otherwise EXC_VECTOR.
  - Any unlisted code also uses EXC_VECTOR.
  - Next state is REFILL.
- REFILL (exactly 1 cycle):
  - flush=0, stall=0.
  - exc_valid is ignored, since the bubble entering MEM carries no valid exception.
  - Stall requests are ignored.
  - Next state is RUN.
- new_pc drives 0 whenever flush=0.
- Run counter:
  - Increments on each clock edge where stall!=0 and flush=0.
  - Cleared on any cycle where stall==0, or when flush=1.
  - When the counter reaches MAX_STALL, stall_timeout is set and stays at 1 until ctr_clr or reset.
  - The run counter saturates at MAX_STALL.
- stall_cycles:
  - Increments on each clock edge where stall!=0.
  - Saturates at all-ones.
- ctr_clr=1: stall_cycles and stall_timeout are both 0 on the next edge. If ctr_clr coincides with an increment or set, the clear wins.
- Reset mid-flush or mid-stall: all outputs return to reset values at once, with no pending redirect.
- Outputs stall, flush and new_pc are combinational from the state and inputs. stall_cycles and stall_timeout are registered.

Test Plan:
- Reset: hold rst=0 with all stallreq=1 and exc_valid=1 -> stall=0, flush=0, new_pc=0, counters 0. Release rst -> normal operation resumes next cycle.
- Priority: stallreq_id=1 and stallreq_ex=1 for 3 cycles -> stall=6'b001111 each cycle, stall_cycles=3. Then stallreq_if alone -> stall=6'b000011.
- Exception over stall: stallreq_mem=1 together with exc_valid=1, exc_code=12 -> same cycle flush=1, stall=0, new_pc=32'h20. Next cycle (REFILL) with exc_valid=1 still held -> flush=0, stall=0.
- eret: cp0_epc=32'h0000_1234, exc_valid=1, exc_code=14 -> flush=1, new_pc=32'h1234 for exactly one cycle.
- Timeout: MAX_STALL=16, stallreq_ex held 16 cycles -> stall_timeout=1 after the 16th edge, 0 after 15. Drop the request -> flag stays 1. Pulse ctr_clr -> flag=0 and stall_cycles=0.
- Run reset by gap: stallreq_ex for 10 cycles, 1 idle cycle, then 10 more -> stall_timeout stays 0 and stall_cycles=20.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 6-stage MIPS core: merges stall requests,
// turns MEM-stage exceptions into a flush plus redirect, and tracks stall statistics.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          MAX_STALL  = 16,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic [31:0]      cp0_epc,
    input  logic             ctr_clr,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);

    localparam int          RCW      = $clog2(MAX_STALL + 1);
    localparam logic [RCW-1:0] RUN_MAX  = RCW'(MAX_STALL);
    localparam logic [RCW-1:0] RUN_LAST = RCW'(MAX_STALL - 1);
    localparam logic [4:0]  CODE_ERET = 5'd14;

    typedef enum logic {RUN, REFILL} state_t;

    state_t         state;
    logic [RCW-1:0] run_cnt;
    logic           stalled;

    // Outputs are gated by reset too, so an asserted reset silences them immediately.
    always_comb begin
        stall  = '0;
        flush  = 1'b0;
        new_pc = '0;
        if (rst && state == RUN) begin
            if (exc_valid) begin
                flush  = 1'b1;
                new_pc = (exc_code == CODE_ERET) ? cp0_epc : EXC_VECTOR;
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end else if (stallreq_if) begin
                stall = 6'b000011;
            end
        end
    end

    assign stalled = (stall != 6'b0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            run_cnt       <= '0;
            stall_cycles  <= '0;
            stall_timeout <= 1'b0;
        end else begin
            case (state)
                RUN:     if (exc_valid) state <= REFILL;
                default: state <= RUN;
            endcase

            // A flush always forces stall to zero, so this also clears on flush.
            if (!stalled)
                run_cnt <= '0;
            else if (run_cnt != RUN_MAX)
                run_cnt <= run_cnt + RCW'(1);

            if (ctr_clr) begin
                stall_cycles  <= '0;
                stall_timeout <= 1'b0;
            end else begin
                if (stalled && stall_cycles != {CNT_W{1'b1}})
                    stall_cycles <= stall_cycles + CNT_W'(1);
                if (stalled && run_cnt >= RUN_LAST)
                    stall_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; inputs change on the falling
// edge and outputs are sampled 1ns later.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_code = 5'd0;
    logic [31:0] cp0_epc = 32'd0;
    logic        ctr_clr = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .MAX_STALL(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exc_valid(exc_valid), .exc_code(exc_code), .cp0_epc(cp0_epc),
        .ctr_clr(ctr_clr),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        exc_valid = 0; exc_code = 0; ctr_clr = 0;
    endtask

    task automatic do_clr();
        @(negedge clk); clear_inputs(); ctr_clr = 1;
        @(negedge clk); ctr_clr = 0;
    endtask

    task automatic test_reset();
        stallreq_if = 1; stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
        exc_valid = 1; exc_code = 5'd12; cp0_epc = 32'h1234;
        @(negedge clk); #1;
        n_cmp++; if (stall !== 6'b0) begin n_bad++; $display("FAIL reset_stall got %b want %b", stall, 6'b0); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush got %b want 0", flush); end
        n_cmp++; if (new_pc !== 32'h0) begin n_bad++; $display("FAIL reset_new_pc got %h want 0", new_pc); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_cycles got %0d want 0", stall_cycles); end
        n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b want 0", stall_timeout); end
        @(negedge clk); rst = 1; clear_inputs(); #1;
        n_cmp++; if (stall !== 6'b0) begin n_bad++; $display("FAIL release_idle got %b want 0", stall); end
        @(negedge clk); stallreq_if = 1; #1;
        n_cmp++; if (stall !== 6'b000011) begin n_bad++; $display("FAIL release_if got %b want 000011", stall); end
        @(negedge clk); stallreq_if = 0; #1;
        n_cmp++; if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL release_cycles got %0d want 1", stall_cycles); end
    endtask

    task automatic test_priority();
        do_clr();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); stallreq_id = 1; stallreq_ex = 1; #1;
            n_cmp++; if (stall !== 6'b001111) begin n_bad++; $display("FAIL prio_ex_id[%0d] got %b want 001111", i, stall); end
        end
        @(negedge clk); stallreq_id = 0; stallreq_ex = 0; stallreq_if = 1; #1;
        n_cmp++; if (stall !== 6'b000011) begin n_bad++; $display("FAIL prio_if got %b want 000011", stall); end
        n_cmp++; if (stall_cycles !== 32'd3) begin n_bad++; $display("FAIL prio_cycles3 got %0d want 3", stall_cycles); end
        @(negedge clk); stallreq_if = 0; stallreq_id = 1; stallreq_mem = 1; #1;
        n_cmp++; if (stall !== 6'b011111) begin n_bad++; $display("FAIL prio_mem got %b want 011111", stall); end
        @(negedge clk); stallreq_mem = 0; #1;
        n_cmp++; if (stall !== 6'b000111) begin n_bad++; $display("FAIL prio_id got %b want 000111", stall); end
        @(negedge clk); clear_inputs(); #1;
        n_cmp++; if (stall_cycles !== 32'd6) begin n_bad++; $display("FAIL prio_cycles6 got %0d want 6", stall_cycles); end
    endtask

    task automatic test_exception();
        @(negedge clk); stallreq_mem = 1; exc_valid = 1; exc_code = 5'd12; #1;
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL exc_flush got %b want 1", flush); end
        n_cmp++; if (stall !== 6'b0) begin n_bad++; $display("FAIL exc_stall got %b want 0", stall); end
        n_cmp++; if (new_pc !== 32'h20) begin n_bad++; $display("FAIL exc_new_pc got %h want 20", new_pc); end
        @(negedge clk); #1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL refill_flush got %b want 0", flush); end
        n_cmp++; if (stall !== 6'b0) begin n_bad++; $display("FAIL refill_stall got %b want 0", stall); end
        n_cmp++; if (new_pc !== 32'h0) begin n_bad++; $display("FAIL refill_new_pc got %h want 0", new_pc); end
        @(negedge clk); exc_valid = 0; #1;
        n_cmp++; if (stall !== 6'b011111) begin n_bad++; $display("FAIL post_refill_stall got %b want 011111", stall); end
        @(negedge clk); stallreq_mem = 0; exc_valid = 1; exc_code = 5'd3; cp0_epc = 32'hdead_beef; #1;
        n_cmp++; if (new_pc !== 32'h20) begin n_bad++; $display("FAIL exc_unlisted got %h want 20", new_pc); end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_eret();
        @(negedge clk); cp0_epc = 32'h0000_1234; exc_valid = 1; exc_code = 5'd14; #1;
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL eret_flush got %b want 1", flush); end
        n_cmp++; if (new_pc !== 32'h1234) begin n_bad++; $display("FAIL eret_new_pc got %h want 1234", new_pc); end
        @(negedge clk); exc_valid = 0; #1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL eret_once got %b want 0", flush); end
        n_cmp++; if (new_pc !== 32'h0) begin n_bad++; $display("FAIL eret_pc_clear got %h want 0", new_pc); end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_timeout();
        do_clr();
        @(negedge clk); stallreq_ex = 1;
        repeat (15) @(negedge clk);
        #1;
        n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_15 got %b want 0", stall_timeout); end
        @(negedge clk); #1;
        n_cmp++; if (stall_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_16 got %b want 1", stall_timeout); end
        stallreq_ex = 0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (stall_timeout !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky got %b want 1", stall_timeout); end
        n_cmp++; if (stall_cycles !== 32'd16) begin n_bad++; $display("FAIL timeout_cycles got %0d want 16", stall_cycles); end
        do_clr(); #1;
        n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL clr_timeout got %b want 0", stall_timeout); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL clr_cycles got %0d want 0", stall_cycles); end
    endtask

    task automatic test_gap();
        do_clr();
        @(negedge clk); stallreq_ex = 1;
        repeat (9) @(negedge clk);
        @(negedge clk); stallreq_ex = 0;
        @(negedge clk); stallreq_ex = 1;
        repeat (9) @(negedge clk);
        @(negedge clk); stallreq_ex = 0; #1;
        n_cmp++; if (stall_timeout !== 1'b0) begin n_bad++; $display("FAIL gap_timeout got %b want 0", stall_timeout); end
        n_cmp++; if (stall_cycles !== 32'd20) begin n_bad++; $display("FAIL gap_cycles got %0d want 20", stall_cycles); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); stallreq_ex = 1;
        @(negedge clk); stallreq_ex = 0; exc_valid = 1; exc_code = 5'd8; #1;
        rst = 0; #1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL midrst_flush got %b want 0", flush); end
        n_cmp++; if (new_pc !== 32'h0) begin n_bad++; $display("FAIL midrst_new_pc got %h want 0", new_pc); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL midrst_cycles got %0d want 0", stall_cycles); end
        @(negedge clk); @(negedge clk); rst = 1; clear_inputs();
        @(negedge clk); stallreq_ex = 1; #1;
        n_cmp++; if (stall !== 6'b001111) begin n_bad++; $display("FAIL midrst_run got %b want 001111", stall); end
        @(negedge clk); clear_inputs();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_exception();
        test_eret();
        test_timeout();
        test_gap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
